// File: rtl/prog_uart_loader.sv
// prog_uart_loader: 8N1 UART receiver plus frame parser (A5, LEN, data, XOR) that fills
// instruction memory and holds the CPU in reset until a frame verifies.
module prog_uart_loader #(
    parameter int CLKS_PER_BIT = 16,
    parameter int MEM_DEPTH    = 25,
    parameter int ADDR_W       = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_data,
    output logic              busy,
    output logic              load_ok,
    output logic              load_err,
    output logic              cpu_rst_n
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_t;
    typedef enum logic [1:0] {P_HDR, P_LEN, P_DATA, P_CHK} ps_t;
    logic rx_m_q, rxs_q;
    rx_t rx_st_q, rx_st_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0] bit_q, bit_d;
    logic [7:0] sh_q, sh_d;
    logic stb_q, stb_d, ferr_q, ferr_d;
    ps_t ps_q, ps_d;
    logic [7:0] left_q, left_d, chk_q, chk_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic mem_we_q, mem_we_d, busy_q, busy_d, ok_q, ok_d, err_q, err_d, cpu_q, cpu_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0] data_q, data_d;
    logic sum_ok;
    always_comb begin
        rx_st_d = rx_st_q;
        cnt_d   = cnt_q + 1'b1;
        bit_d   = bit_q;
        sh_d    = sh_q;
        stb_d   = 1'b0;
        ferr_d  = 1'b0;
        case (rx_st_q)
            IDLE: begin
                cnt_d = '0;
                if (!rxs_q) rx_st_d = START;
            end
            START: if (cnt_q == HALF) begin
                cnt_d   = '0;
                bit_d   = '0;
                rx_st_d = rxs_q ? IDLE : DATA;
            end
            DATA: if (cnt_q == FULL) begin
                cnt_d = '0;
                sh_d  = {rxs_q, sh_q[7:1]};
                bit_d = bit_q + 1'b1;
                if (bit_q == 3'd7) rx_st_d = STOP;
            end
            default: if (cnt_q == FULL) begin
                rx_st_d = IDLE;
                stb_d   = rxs_q;
                ferr_d  = !rxs_q;
            end
        endcase
    end
    // sh_q holds the received byte while the strobe is high; the parser reads it directly
    always_comb begin
        ps_d     = ps_q;
        left_d   = left_q;
        chk_d    = chk_q;
        idx_d    = idx_q;
        mem_we_d = 1'b0;
        addr_d   = addr_q;
        data_d   = data_q;
        busy_d   = busy_q;
        ok_d     = ok_q;
        err_d    = err_q;
        cpu_d    = cpu_q;
        sum_ok   = (sh_q == chk_q);
        if (ferr_q) begin
            ps_d   = P_HDR;
            err_d  = 1'b1;
            ok_d   = 1'b0;
            busy_d = 1'b0;
            cpu_d  = 1'b0;
        end else if (stb_q) begin
            case (ps_q)
                P_HDR: if (sh_q == 8'hA5) begin
                    ps_d  = P_LEN;
                    ok_d  = 1'b0;
                    err_d = 1'b0;
                end
                P_LEN: if (sh_q != 8'd0 && sh_q <= 8'(MEM_DEPTH)) begin
                    ps_d   = P_DATA;
                    left_d = sh_q;
                    idx_d  = '0;
                    chk_d  = '0;
                    busy_d = 1'b1;
                    cpu_d  = 1'b0;
                end else begin
                    ps_d  = P_HDR;
                    err_d = 1'b1;
                end
                P_DATA: begin
                    mem_we_d = 1'b1;
                    addr_d   = idx_q;
                    data_d   = sh_q;
                    chk_d    = chk_q ^ sh_q;
                    idx_d    = idx_q + 1'b1;
                    left_d   = left_q - 8'd1;
                    if (left_q == 8'd1) ps_d = P_CHK;
                end
                default: begin
                    ps_d   = P_HDR;
                    busy_d = 1'b0;
                    ok_d   = sum_ok;
                    err_d  = !sum_ok;
                    cpu_d  = sum_ok;
                end
            endcase
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_m_q   <= 1'b1;
            rxs_q    <= 1'b1;
            rx_st_q  <= IDLE;
            cnt_q    <= '0;
            bit_q    <= '0;
            sh_q     <= '0;
            stb_q    <= 1'b0;
            ferr_q   <= 1'b0;
            ps_q     <= P_HDR;
            left_q   <= '0;
            chk_q    <= '0;
            idx_q    <= '0;
            mem_we_q <= 1'b0;
            addr_q   <= '0;
            data_q   <= '0;
            busy_q   <= 1'b0;
            ok_q     <= 1'b0;
            err_q    <= 1'b0;
            cpu_q    <= 1'b0;
        end else begin
            rx_m_q   <= rx;
            rxs_q    <= rx_m_q;
            rx_st_q  <= rx_st_d;
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            sh_q     <= sh_d;
            stb_q    <= stb_d;
            ferr_q   <= ferr_d;
            ps_q     <= ps_d;
            left_q   <= left_d;
            chk_q    <= chk_d;
            idx_q    <= idx_d;
            mem_we_q <= mem_we_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            busy_q   <= busy_d;
            ok_q     <= ok_d;
            err_q    <= err_d;
            cpu_q    <= cpu_d;
        end
    end
    assign mem_we    = mem_we_q;
    assign mem_addr  = addr_q;
    assign mem_data  = data_q;
    assign busy      = busy_q;
    assign load_ok   = ok_q;
    assign load_err  = err_q;
    assign cpu_rst_n = cpu_q;
endmodule

// File: tb/tb_prog_uart_loader.sv
// tb_prog_uart_loader: directed frame sequences for prog_uart_loader with logged memory writes.
module tb_prog_uart_loader;
    localparam int CPB = 16;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rx = 1'b1;
    logic mem_we, busy, load_ok, load_err, cpu_rst_n;
    logic [4:0] mem_addr;
    logic [7:0] mem_data;
    int total = 0;
    int bad = 0;
    int wr_n = 0;
    int busy_n = 0;
    logic [4:0] wa [64];
    logic [7:0] wd [64];
    int b, bb;

    prog_uart_loader #(.CLKS_PER_BIT(CPB), .MEM_DEPTH(25), .ADDR_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .rx(rx), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_data(mem_data), .busy(busy), .load_ok(load_ok), .load_err(load_err),
        .cpu_rst_n(cpu_rst_n)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mem_we) begin
            if (wr_n < 64) begin
                wa[wr_n] = mem_addr;
                wd[wr_n] = mem_data;
            end
            wr_n++;
        end
        if (busy) busy_n++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] v, input logic stop = 1'b1);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = v[i];
            repeat (CPB) @(negedge clk);
        end
        rx = stop;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
        if (!stop) repeat (2 * CPB) @(negedge clk);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_we"}, 32'(mem_we), 0);
        chk({tag, "_addr"}, 32'(mem_addr), 0);
        chk({tag, "_data"}, 32'(mem_data), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_ok"}, 32'(load_ok), 0);
        chk({tag, "_err"}, 32'(load_err), 0);
        chk({tag, "_cpu"}, 32'(cpu_rst_n), 0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk_reset("rst");
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // good load
        b = wr_n;
        send(8'hA5); send(8'h03);
        chk("good_busy_len", 32'(busy), 1);
        chk("good_cpu_len", 32'(cpu_rst_n), 0);
        send(8'h01); send(8'h2A); send(8'h0A);
        chk("good_busy_data", 32'(busy), 1);
        send(8'h21);
        repeat (4) @(negedge clk);
        chk("good_nwr", 32'(wr_n - b), 3);
        chk("good_a0", 32'(wa[b]), 0);   chk("good_d0", 32'(wd[b]), 32'h01);
        chk("good_a1", 32'(wa[b+1]), 1); chk("good_d1", 32'(wd[b+1]), 32'h2A);
        chk("good_a2", 32'(wa[b+2]), 2); chk("good_d2", 32'(wd[b+2]), 32'h0A);
        chk("good_busy", 32'(busy), 0);
        chk("good_ok", 32'(load_ok), 1);
        chk("good_err", 32'(load_err), 0);
        chk("good_cpu", 32'(cpu_rst_n), 1);

        // bad checksum
        b = wr_n;
        send(8'hA5); send(8'h02); send(8'h01); send(8'h02); send(8'h00);
        repeat (4) @(negedge clk);
        chk("badchk_nwr", 32'(wr_n - b), 2);
        chk("badchk_a1", 32'(wa[b+1]), 1); chk("badchk_d1", 32'(wd[b+1]), 32'h02);
        chk("badchk_err", 32'(load_err), 1);
        chk("badchk_ok", 32'(load_ok), 0);
        chk("badchk_cpu", 32'(cpu_rst_n), 0);
        chk("badchk_busy", 32'(busy), 0);

        // length bounds
        b = wr_n; bb = busy_n;
        send(8'hA5);
        chk("len0_hdr_clr", 32'(load_err), 0);
        send(8'h00);
        repeat (4) @(negedge clk);
        chk("len0_err", 32'(load_err), 1);
        send(8'hA5); send(8'h1A);
        repeat (4) @(negedge clk);
        chk("len26_err", 32'(load_err), 1);
        chk("len_nwr", 32'(wr_n - b), 0);
        chk("len_busy_never", 32'(busy_n - bb), 0);

        // full-depth frame: bytes 1..25, XOR = 0x01
        b = wr_n;
        send(8'hA5); send(8'h19);
        for (int i = 1; i <= 25; i++) send(8'(i));
        send(8'h01);
        repeat (4) @(negedge clk);
        chk("full_nwr", 32'(wr_n - b), 25);
        for (int i = 0; i < 25; i++) begin
            chk($sformatf("full_a%0d", i), 32'(wa[b+i]), 32'(i));
            chk($sformatf("full_d%0d", i), 32'(wd[b+i]), 32'(i + 1));
        end
        chk("full_ok", 32'(load_ok), 1);
        chk("full_cpu", 32'(cpu_rst_n), 1);

        // framing error in P_DATA
        b = wr_n;
        send(8'hA5); send(8'h02); send(8'h55);
        send(8'h66, 1'b0);
        chk("ferr_nwr", 32'(wr_n - b), 1);
        chk("ferr_d0", 32'(wd[b]), 32'h55);
        chk("ferr_err", 32'(load_err), 1);
        chk("ferr_ok", 32'(load_ok), 0);
        chk("ferr_busy", 32'(busy), 0);
        chk("ferr_cpu", 32'(cpu_rst_n), 0);
        send(8'h01); send(8'h07);
        repeat (4) @(negedge clk);
        chk("ferr_hdr_nwr", 32'(wr_n - b), 1);
        chk("ferr_hdr_err", 32'(load_err), 1);

        // 3-clock glitch
        b = wr_n; bb = busy_n;
        rx = 1'b0;
        repeat (3) @(negedge clk);
        rx = 1'b1;
        repeat (40) @(negedge clk);
        chk("glitch_nwr", 32'(wr_n - b), 0);
        chk("glitch_busy", 32'(busy_n - bb), 0);
        chk("glitch_err", 32'(load_err), 1);

        // reset mid-load
        send(8'hA5); send(8'h03); send(8'h11); send(8'h22);
        repeat (4) @(negedge clk);
        chk("mid_busy", 32'(busy), 1);
        rst_n = 1'b0;
        #1;
        chk_reset("midrst");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        b = wr_n;
        send(8'hA5); send(8'h02); send(8'h33); send(8'h44); send(8'h77);
        repeat (4) @(negedge clk);
        chk("rel_nwr", 32'(wr_n - b), 2);
        chk("rel_a0", 32'(wa[b]), 0);   chk("rel_d0", 32'(wd[b]), 32'h33);
        chk("rel_a1", 32'(wa[b+1]), 1); chk("rel_d1", 32'(wd[b+1]), 32'h44);
        chk("rel_ok", 32'(load_ok), 1);
        chk("rel_cpu", 32'(cpu_rst_n), 1);

        // noise before header
        b = wr_n;
        send(8'h00); send(8'hFF); send(8'hA5); send(8'h01); send(8'h07); send(8'h07);
        repeat (4) @(negedge clk);
        chk("noise_nwr", 32'(wr_n - b), 1);
        chk("noise_a0", 32'(wa[b]), 0);
        chk("noise_d0", 32'(wd[b]), 32'h07);
        chk("noise_ok", 32'(load_ok), 1);
        chk("noise_err", 32'(load_err), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
